// File: rtl/ahb_slave_arbiter.sv
// ============================================================================
// Module      : ahb_slave_arbiter
// Description : Per-slave round-robin AHB arbiter with burst/lock retention.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_slave_arbiter #(
  parameter int SLAVE_X_MASTER_NUM = 3,
  parameter int MAX_HOLD           = 16,
  parameter int MIDX_W             = $clog2(SLAVE_X_MASTER_NUM)
) (
  input  logic                                i_hclk,
  input  logic                                i_hreset,
  input  logic [SLAVE_X_MASTER_NUM-1:0]       i_hreq,
  input  logic [SLAVE_X_MASTER_NUM-1:0][1:0]  i_htrans,
  input  logic [SLAVE_X_MASTER_NUM-1:0]       i_hlock,
  input  logic                                i_hready,
  output logic [SLAVE_X_MASTER_NUM-1:0]       o_hgrant,
  output logic                                o_hsel,
  output logic [MIDX_W-1:0]                   o_hmaster,
  output logic [MIDX_W-1:0]                   o_hmaster_data,
  output logic                                o_hmastlock
);

  localparam int N      = SLAVE_X_MASTER_NUM;
  localparam int HOLD_W = $clog2(MAX_HOLD);

  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [1:0] C_HT_IDLE   = 2'b00;
  localparam logic [1:0] C_HT_NONSEQ = 2'b10;

  localparam logic [1:0] C_ARB_IDLE = 2'd0;
  localparam logic [1:0] C_ARB_OWN  = 2'd1;
  localparam logic [1:0] C_ARB_LOCK = 2'd2;

  logic [1:0]        r_state;
  logic [N-1:0]      r_hgrant;
  logic [MIDX_W-1:0] r_rr_ptr;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [MIDX_W-1:0] r_hmaster_data;

  logic [1:0]        w_state_nxt;
  logic [N-1:0]      w_grant_nxt;
  logic [MIDX_W-1:0] w_rr_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_rearb;
  logic              w_win_found;
  logic [MIDX_W-1:0] w_win_idx;
  logic [MIDX_W-1:0] w_hmaster;
  logic [1:0]        w_own_trans;
  logic              w_own_lock;
  logic              w_own_keep;
  logic              w_other_req;
  logic              w_preempt;
  logic              w_hsel;

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_state        <= C_ARB_IDLE;
      r_hgrant       <= '0;
      r_rr_ptr       <= '0;
      r_hold_cnt     <= '0;
      r_hmaster_data <= '0;
    end else if (i_hready) begin
      r_state    <= w_state_nxt;
      r_hgrant   <= w_grant_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_hold_cnt <= w_hold_nxt;
      if (w_hsel) begin
        r_hmaster_data <= w_hmaster;
      end
    end
  end

  // Round-robin search starts just after the last winner
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!w_win_found && i_hreq[(int'(r_rr_ptr) + k) % N]) begin
        w_win_found = 1'b1;
        w_win_idx   = MIDX_W'((int'(r_rr_ptr) + k) % N);
      end
    end
  end

  // BUSY (01) and SEQ (11) both have bit 0 set: the owner is mid-burst
  assign w_own_trans = i_htrans[w_hmaster];
  assign w_own_lock  = i_hlock[w_hmaster];
  assign w_own_keep  = w_own_trans[0] | w_own_lock;
  assign w_other_req = |(i_hreq & ~r_hgrant);
  assign w_preempt   = (r_hold_cnt == C_HOLD_LAST) && w_other_req && !w_own_lock;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_hgrant;
    w_rr_nxt    = r_rr_ptr;
    w_hold_nxt  = r_hold_cnt;
    w_rearb     = 1'b0;
    case (r_state)
      C_ARB_IDLE: w_rearb = w_win_found;
      C_ARB_OWN: begin
        if (w_own_lock && (w_own_trans == C_HT_NONSEQ)) begin
          w_state_nxt = C_ARB_LOCK;
        end else if (w_own_keep && !w_preempt) begin
          if (r_hold_cnt != C_HOLD_LAST) begin
            w_hold_nxt = r_hold_cnt + 1'b1;
          end
        end else begin
          w_rearb = 1'b1;
        end
      end
      C_ARB_LOCK: w_rearb = !w_own_keep;
      default:    w_state_nxt = C_ARB_IDLE;
    endcase
    if (w_rearb) begin
      w_hold_nxt = '0;
      if (w_win_found) begin
        w_grant_nxt = N'(1) << w_win_idx;
        w_rr_nxt    = w_win_idx;
        w_state_nxt = C_ARB_OWN;
      end else begin
        w_grant_nxt = '0;
        w_state_nxt = C_ARB_IDLE;
      end
    end
  end

  always_comb begin
    w_hmaster = '0;
    for (int i = 0; i < N; i++) begin
      if (r_hgrant[i]) begin
        w_hmaster = MIDX_W'(i);
      end
    end
    w_hsel = (|(r_hgrant & i_hreq)) && (i_htrans[w_hmaster] != C_HT_IDLE);
  end

  assign o_hgrant       = r_hgrant;
  assign o_hsel         = w_hsel;
  assign o_hmaster      = w_hmaster;
  assign o_hmaster_data = r_hmaster_data;
  assign o_hmastlock    = i_hlock[w_hmaster] & (|r_hgrant);

endmodule

`default_nettype wire
